// File: rtl/i4001_pkg.sv
// Shared MCS-4 bus definitions for the 4001 ROM/IO bank: bus phases,
// I/O opcodes, and the chip-number range check used by fetch and SRC.
package i4001_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  localparam logic [3:0] OPA_WRR = 4'b0010;
  localparam logic [3:0] OPA_RDR = 4'b1010;

  function automatic logic chip_in_range(input logic [3:0] chip,
                                         input logic [3:0] base,
                                         input int         count);
    return (int'(chip) >= int'(base)) && (int'(chip) < int'(base) + count);
  endfunction

endpackage

// File: rtl/i4001_phase_tracker.sv
// Follows the eight MCS-4 bus phases from clk2 falling edges seen in the
// sysclk domain; parks in X3 until a SYNC-qualified X3 restarts the cycle.
module i4001_phase_tracker
  import i4001_pkg::*;
(
  input  logic   sysclk,
  input  logic   poc_n,
  input  logic   i_clk2,
  input  logic   i_sync,
  output phase_e o_phase,
  output logic   o_evt
);

  phase_e r_phase;
  phase_e w_phase_nxt;
  logic   r_clk2;
  logic   r_sync;
  logic   r_sync_seen;
  logic   w_sync_seen_nxt;

  assign o_evt   = r_clk2 & ~i_clk2;
  assign o_phase = r_phase;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_clk2      <= 1'b0;
      r_sync      <= 1'b0;
      r_sync_seen <= 1'b0;
      r_phase     <= PH_X3;
    end else begin
      r_clk2      <= i_clk2;
      r_sync      <= i_sync;
      r_sync_seen <= w_sync_seen_nxt;
      r_phase     <= w_phase_nxt;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    w_phase_nxt     = r_phase;
    w_sync_seen_nxt = (r_phase == PH_X3) & (r_sync_seen | r_sync);
    if (o_evt) begin
      w_sync_seen_nxt = 1'b0;
      case (r_phase)
        PH_X3:   if (r_sync_seen | r_sync) w_phase_nxt = PH_A1;
        default: w_phase_nxt = phase_e'(r_phase + 3'd1);
      endcase
    end
  end

endmodule

// File: rtl/i4001_bank.sv
// Emulates NUM_CHIPS consecutive 4001 ROM/IO chips on the MCS-4 bus.
// Define I4001_BANK_INPUT_SYNC_EN to double-register io_in before use.
module i4001_bank
  import i4001_pkg::*;
#(
  parameter logic [3:0]             BASE_ROM  = 4'd0,
  parameter int                     NUM_CHIPS = 2,
  parameter logic [4*NUM_CHIPS-1:0] IO_OUTPUT = '0,
  parameter logic [4*NUM_CHIPS-1:0] IO_INVERT = '0
) (
  input  logic                   sysclk,
  input  logic                   poc_n,
  input  logic                   clk1,
  input  logic                   clk2,
  input  logic                   sync,
  input  logic                   cmrom,
  input  logic [3:0]             data_in,
  output logic [3:0]             data_out,
  output logic                   data_oe,
  input  logic [4*NUM_CHIPS-1:0] io_in,
  output logic [4*NUM_CHIPS-1:0] io_out,
  input  logic                   clear,
  output logic [11:0]            rom_addr,
  output logic                   rom_en,
  input  logic [7:0]             rom_data
);

  localparam int W = 4 * NUM_CHIPS;

  generate
    if (int'(BASE_ROM) + NUM_CHIPS > 16 || NUM_CHIPS < 1) begin : g_bad_cfg
      $error("i4001_bank: chip range must be non-empty and fit in 0..15");
    end
  endgenerate

  phase_e      w_phase;
  logic        w_evt;
  logic        w_hit;
  logic        r_cmrom;
  logic [3:0]  r_data_in;
  logic [7:0]  r_fetch_addr;
  logic        r_chipsel;
  logic [11:0] r_rom_addr;
  logic        r_rom_en;
  logic        r_rom_en_d;
  logic [7:0]  r_hold;
  logic        r_src_valid;
  logic [3:0]  r_src_idx;
  logic        r_wrr_pend;
  logic        r_rdr_pend;
  logic [W-1:0] r_latch;
  logic [W-1:0] w_io;
  logic [W-1:0] w_rd_bits;
  logic [3:0]   w_rd_nib;
  logic         w_unused;

  // clk1 carries no information the clk2-based phase tracking needs.
  assign w_unused = &{1'b0, clk1};

  i4001_phase_tracker u_phase (
    .sysclk  (sysclk),
    .poc_n   (poc_n),
    .i_clk2  (clk2),
    .i_sync  (sync),
    .o_phase (w_phase),
    .o_evt   (w_evt)
  );

  assign w_hit = chip_in_range(r_data_in, BASE_ROM, NUM_CHIPS);

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_cmrom      <= 1'b0;
      r_data_in    <= '0;
      r_fetch_addr <= '0;
      r_chipsel    <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_en     <= 1'b0;
      r_rom_en_d   <= 1'b0;
      r_hold       <= '0;
      r_src_valid  <= 1'b0;
      r_src_idx    <= '0;
      r_wrr_pend   <= 1'b0;
      r_rdr_pend   <= 1'b0;
    end else begin
      r_cmrom    <= cmrom;
      r_data_in  <= data_in;
      r_rom_en   <= 1'b0;
      r_rom_en_d <= r_rom_en;
      // Block RAM answers one sysclk after the enable pulse.
      if (r_rom_en_d) r_hold <= rom_data;
      if (w_evt) begin
        case (w_phase)
          PH_A1: begin
            r_fetch_addr[3:0] <= r_data_in;
            r_wrr_pend        <= 1'b0;
            r_rdr_pend        <= 1'b0;
          end
          PH_A2: r_fetch_addr[7:4] <= r_data_in;
          PH_A3: begin
            r_chipsel <= r_cmrom & w_hit;
            if (r_cmrom && w_hit) begin
              r_rom_addr <= {r_data_in, r_fetch_addr};
              r_rom_en   <= 1'b1;
            end
          end
          PH_M2: begin
            if (r_cmrom && r_src_valid) begin
              r_wrr_pend <= (r_data_in == OPA_WRR);
              r_rdr_pend <= (r_data_in == OPA_RDR);
            end
          end
          PH_X2: begin
            if (r_cmrom) begin
              r_src_valid <= w_hit;
              r_src_idx   <= r_data_in - BASE_ROM;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the output latches drive pins, so unlike a plain storage array
  // they must come out of reset in a known state.
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_latch <= '0;
    end else if (clear) begin
      r_latch <= '0;
    end else if (w_evt && w_phase == PH_X2 && r_wrr_pend) begin
      for (int c = 0; c < NUM_CHIPS; c++) begin
        if (r_src_idx == 4'(c)) r_latch[4*c +: 4] <= r_data_in;
      end
    end
  end

`ifdef I4001_BANK_INPUT_SYNC_EN
  logic [W-1:0] r_io_meta;
  logic [W-1:0] r_io_sync;

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      r_io_meta <= '0;
      r_io_sync <= '0;
    end else begin
      r_io_meta <= io_in;
      r_io_sync <= r_io_meta;
    end
  end

  assign w_io = r_io_sync;
`else
  assign w_io = io_in;
`endif

  // Output pins read back their latch; input pins read the (inverted) pad.
  assign w_rd_bits = (IO_OUTPUT & r_latch) | (~IO_OUTPUT & (w_io ^ IO_INVERT));
  assign io_out    = (r_latch ^ IO_INVERT) & IO_OUTPUT;

  always_comb begin
    w_rd_nib = '0;
    for (int c = 0; c < NUM_CHIPS; c++) begin
      if (r_src_idx == 4'(c)) w_rd_nib = w_rd_bits[4*c +: 4];
    end
  end

  always_comb begin
    data_oe  = 1'b0;
    data_out = '0;
    case (w_phase)
      PH_M1: if (r_chipsel) begin
        data_oe  = 1'b1;
        data_out = r_hold[7:4];
      end
      PH_M2: if (r_chipsel) begin
        data_oe  = 1'b1;
        data_out = r_hold[3:0];
      end
      PH_X2: if (r_rdr_pend) begin
        data_oe  = 1'b1;
        data_out = w_rd_nib;
      end
      default: ;
    endcase
  end

  assign rom_addr = r_rom_addr;
  assign rom_en   = r_rom_en;

endmodule

// File: tb/tb_i4001_bank.sv
// Directed bench for i4001_bank: fetch, miss, WRR/RDR, clear, reset and idle
// behaviour on a two-chip bank at chips 2..3.
module tb_i4001_bank;

  localparam int P_A1 = 0;
  localparam int P_M1 = 3;
  localparam int P_M2 = 4;
  localparam int P_X2 = 6;

  logic        sysclk = 1'b0;
  logic        poc_n;
  logic        clk1;
  logic        clk2;
  logic        sync;
  logic        cmrom;
  logic        clear;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        data_oe;
  logic [7:0]  io_in;
  logic [7:0]  io_out;
  logic [11:0] rom_addr;
  logic        rom_en;
  logic [7:0]  rom_data;
  logic [7:0]  rom_mem [4096];

  int n_checks = 0;
  int n_fail   = 0;
  int rom_en_total = 0;
  int rom_en_mark;

  logic        p_all;
  logic        p_any;
  logic [3:0]  p_dout;
  logic [7:0]  ph_oe_all;
  logic [7:0]  ph_oe_any;
  logic [31:0] ph_dout;

  i4001_bank #(
    .BASE_ROM  (4'd2),
    .NUM_CHIPS (2),
    .IO_OUTPUT (8'hF0),
    .IO_INVERT (8'h10)
  ) dut (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .clk1     (clk1),
    .clk2     (clk2),
    .sync     (sync),
    .cmrom    (cmrom),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .io_in    (io_in),
    .io_out   (io_out),
    .clear    (clear),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .rom_data (rom_data)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) begin
    if (rom_en === 1'b1) begin
      rom_data <= rom_mem[rom_addr];
      rom_en_total <= rom_en_total + 1;
    end
  end

  // One bus phase: clk2 high for three sysclks, then low across the event edge.
  task automatic bus_phase(input logic [3:0] din, input logic cm,
                           input logic sy, input logic clr);
    @(negedge sysclk);
    data_in = din;
    cmrom   = cm;
    sync    = sy;
    clear   = 1'b0;
    clk2    = 1'b1;
    p_all   = 1'b1;
    p_any   = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      p_all = p_all & data_oe;
      p_any = p_any | data_oe;
    end
    p_dout = data_out;
    clk2   = 1'b0;
    clear  = clr;
    @(posedge sysclk);
  endtask

  // d holds one nibble per phase, A1 in d[3:0] through X3 in d[31:28].
  task automatic run_cycle(input logic [31:0] d, input logic [7:0] cm,
                           input logic [7:0] clr, input logic sync_x3);
    for (int i = 0; i < 8; i++) begin
      bus_phase(d[4*i +: 4], cm[i], (i == 7) ? sync_x3 : 1'b0, clr[i]);
      ph_oe_all[i]       = p_all;
      ph_oe_any[i]       = p_any;
      ph_dout[4*i +: 4]  = p_dout;
    end
  endtask

  task automatic test_reset;
    poc_n = 1'b0;
    repeat (3) @(negedge sysclk);
    poc_n = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if (data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", data_oe); end
    n_checks++;
    if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", data_out); end
    n_checks++;
    if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b expected 0", rom_en); end
    n_checks++;
    if (rom_addr !== 12'h000) begin n_fail++; $display("FAIL reset_rom_addr: got %h expected 000", rom_addr); end
    n_checks++;
    if (io_out !== 8'h10) begin n_fail++; $display("FAIL reset_io_out: got %h expected 10", io_out); end
  endtask

  task automatic test_fetch;
    bus_phase(4'h0, 1'b0, 1'b1, 1'b0);
    rom_en_mark = rom_en_total;
    run_cycle(32'h0000_03A5, 8'h04, 8'h00, 1'b1);
    n_checks++;
    if (rom_en_total - rom_en_mark !== 1) begin n_fail++; $display("FAIL fetch_rom_en_pulses: got %0d expected 1", rom_en_total - rom_en_mark); end
    n_checks++;
    if (rom_addr !== 12'h3A5) begin n_fail++; $display("FAIL fetch_rom_addr: got %h expected 3a5", rom_addr); end
    n_checks++;
    if (ph_oe_all[P_M1] !== 1'b1 || ph_dout[4*P_M1 +: 4] !== 4'hC) begin
      n_fail++; $display("FAIL fetch_m1: got oe=%b data=%h expected oe=1 data=c", ph_oe_all[P_M1], ph_dout[4*P_M1 +: 4]);
    end
    n_checks++;
    if (ph_oe_all[P_M2] !== 1'b1 || ph_dout[4*P_M2 +: 4] !== 4'h7) begin
      n_fail++; $display("FAIL fetch_m2: got oe=%b data=%h expected oe=1 data=7", ph_oe_all[P_M2], ph_dout[4*P_M2 +: 4]);
    end
    n_checks++;
    if ((ph_oe_any & 8'b1110_0111) !== 8'h00) begin n_fail++; $display("FAIL fetch_quiet_phases: got %b expected 00000000", ph_oe_any & 8'b1110_0111); end
  endtask

  task automatic test_back_to_back;
    run_cycle(32'h0000_02B4, 8'h04, 8'h00, 1'b1);
    n_checks++;
    if (rom_addr !== 12'h2B4) begin n_fail++; $display("FAIL b2b_rom_addr: got %h expected 2b4", rom_addr); end
    n_checks++;
    if (ph_oe_all[P_M1] !== 1'b1 || ph_dout[4*P_M1 +: 4] !== 4'h5) begin
      n_fail++; $display("FAIL b2b_m1: got oe=%b data=%h expected oe=1 data=5", ph_oe_all[P_M1], ph_dout[4*P_M1 +: 4]);
    end
    n_checks++;
    if (ph_oe_all[P_M2] !== 1'b1 || ph_dout[4*P_M2 +: 4] !== 4'hE) begin
      n_fail++; $display("FAIL b2b_m2: got oe=%b data=%h expected oe=1 data=e", ph_oe_all[P_M2], ph_dout[4*P_M2 +: 4]);
    end
  endtask

  task automatic test_miss;
    rom_en_mark = rom_en_total;
    run_cycle(32'h0000_04A5, 8'h04, 8'h00, 1'b1);
    n_checks++;
    if (rom_en_total - rom_en_mark !== 0) begin n_fail++; $display("FAIL miss_chip4_rom_en: got %0d expected 0", rom_en_total - rom_en_mark); end
    n_checks++;
    if (ph_oe_any !== 8'h00) begin n_fail++; $display("FAIL miss_chip4_oe: got %b expected 00000000", ph_oe_any); end
    rom_en_mark = rom_en_total;
    run_cycle(32'h0000_03A5, 8'h00, 8'h00, 1'b1);
    n_checks++;
    if (rom_en_total - rom_en_mark !== 0) begin n_fail++; $display("FAIL miss_nocm_rom_en: got %0d expected 0", rom_en_total - rom_en_mark); end
    n_checks++;
    if (ph_oe_any !== 8'h00) begin n_fail++; $display("FAIL miss_nocm_oe: got %b expected 00000000", ph_oe_any); end
  endtask

  task automatic test_wrr;
    run_cycle(32'h0300_0000, 8'h40, 8'h00, 1'b1);
    run_cycle(32'h0902_0000, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (io_out !== 8'h80) begin n_fail++; $display("FAIL wrr_io_out: got %h expected 80", io_out); end
  endtask

  task automatic test_rdr;
    run_cycle(32'h0200_0000, 8'h40, 8'h00, 1'b1);
    run_cycle(32'h000A_0000, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (ph_oe_all[P_X2] !== 1'b1 || ph_dout[4*P_X2 +: 4] !== 4'h6) begin
      n_fail++; $display("FAIL rdr_chip2: got oe=%b data=%h expected oe=1 data=6", ph_oe_all[P_X2], ph_dout[4*P_X2 +: 4]);
    end
    n_checks++;
    if ((ph_oe_any & 8'b1011_1111) !== 8'h00) begin n_fail++; $display("FAIL rdr_quiet_phases: got %b expected 00000000", ph_oe_any & 8'b1011_1111); end
    run_cycle(32'h0300_0000, 8'h40, 8'h00, 1'b1);
    run_cycle(32'h000A_0000, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (ph_oe_all[P_X2] !== 1'b1 || ph_dout[4*P_X2 +: 4] !== 4'h9) begin
      n_fail++; $display("FAIL rdr_chip3_readback: got oe=%b data=%h expected oe=1 data=9", ph_oe_all[P_X2], ph_dout[4*P_X2 +: 4]);
    end
    run_cycle(32'h0500_0000, 8'h40, 8'h00, 1'b1);
    run_cycle(32'h000A_0000, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (ph_oe_any !== 8'h00) begin n_fail++; $display("FAIL rdr_src_out_of_range: got %b expected 00000000", ph_oe_any); end
  endtask

  task automatic test_clear;
    run_cycle(32'h0300_0000, 8'h40, 8'h00, 1'b1);
    run_cycle(32'h0502_0000, 8'h10, 8'h40, 1'b1);
    n_checks++;
    if (io_out !== 8'h10) begin n_fail++; $display("FAIL clear_vs_wrr: got %h expected 10", io_out); end
    run_cycle(32'h0502_0000, 8'h10, 8'h00, 1'b1);
    n_checks++;
    if (io_out !== 8'h40) begin n_fail++; $display("FAIL wrr_after_clear: got %h expected 40", io_out); end
  endtask

  task automatic test_reset_mid;
    bus_phase(4'h5, 1'b0, 1'b0, 1'b0);
    bus_phase(4'hA, 1'b0, 1'b0, 1'b0);
    bus_phase(4'h3, 1'b1, 1'b0, 1'b0);
    @(negedge sysclk);
    data_in = 4'h0;
    cmrom   = 1'b0;
    clk2    = 1'b1;
    @(negedge sysclk);
    n_checks++;
    if (data_oe !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_oe: got %b expected 1", data_oe); end
    poc_n = 1'b0;
    #1;
    n_checks++;
    if (data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_mid_oe: got %b expected 0", data_oe); end
    n_checks++;
    if (data_out !== 4'h0) begin n_fail++; $display("FAIL rst_mid_dout: got %h expected 0", data_out); end
    n_checks++;
    if (io_out !== 8'h10) begin n_fail++; $display("FAIL rst_mid_io_out: got %h expected 10", io_out); end
    @(negedge sysclk);
    poc_n = 1'b1;
    clk2  = 1'b0;
    @(negedge sysclk);
    rom_en_mark = rom_en_total;
    run_cycle(32'h0000_03A5, 8'h04, 8'h00, 1'b1);
    n_checks++;
    if (ph_oe_any !== 8'h00 || rom_en_total - rom_en_mark !== 0) begin
      n_fail++; $display("FAIL rst_mid_no_sync_cycle: got oe=%b rom_en=%0d expected oe=00000000 rom_en=0", ph_oe_any, rom_en_total - rom_en_mark);
    end
    run_cycle(32'h0000_03A5, 8'h04, 8'h00, 1'b0);
    n_checks++;
    if (ph_oe_all[P_M1] !== 1'b1 || ph_dout[4*P_M1 +: 4] !== 4'hC) begin
      n_fail++; $display("FAIL rst_mid_resume_m1: got oe=%b data=%h expected oe=1 data=c", ph_oe_all[P_M1], ph_dout[4*P_M1 +: 4]);
    end
  endtask

  task automatic test_idle;
    logic any_oe;
    any_oe = 1'b0;
    rom_en_mark = rom_en_total;
    for (int i = 0; i < 20; i++) begin
      bus_phase(4'(i), 1'b1, 1'b0, 1'b0);
      any_oe = any_oe | p_any;
    end
    n_checks++;
    if (any_oe !== 1'b0) begin n_fail++; $display("FAIL idle_oe: got %b expected 0", any_oe); end
    run_cycle(32'h0000_03A5, 8'h04, 8'h00, 1'b0);
    n_checks++;
    if (ph_oe_any !== 8'h00) begin n_fail++; $display("FAIL idle_fetch_oe: got %b expected 00000000", ph_oe_any); end
    n_checks++;
    if (rom_en_total - rom_en_mark !== 0) begin n_fail++; $display("FAIL idle_rom_en: got %0d expected 0", rom_en_total - rom_en_mark); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) rom_mem[a] = 8'h00;
    rom_mem[12'h3A5] = 8'hC7;
    rom_mem[12'h2B4] = 8'h5E;
    poc_n   = 1'b0;
    clk1    = 1'b0;
    clk2    = 1'b0;
    sync    = 1'b0;
    cmrom   = 1'b0;
    clear   = 1'b0;
    data_in = 4'h0;
    io_in   = 8'h36;

    test_reset();
    test_fetch();
    test_back_to_back();
    test_miss();
    test_wrr();
    test_rdr();
    test_clear();
    test_reset_mid();
    test_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
